// File: rtl/mc68881_bus_master.sv
// Host-to-MC68881 coprocessor bus master: one host request becomes one or three
// 32-bit asynchronous bus subcycles, each closed by a DSACK handshake or a timeout.
module mc68881_bus_master #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned GAP     = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req,
   input  logic [1:0]  kind,
   input  logic [4:0]  addr,
   input  logic        ext80,
   input  logic [79:0] wdata,
   output logic [79:0] rdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic        CS,
   output logic        AS,
   output logic        DS,
   output logic        R_W,
   output logic        SIZE,
   output logic [4:0]  A,
   output logic [31:0] D_out,
   output logic        D_oe,
   input  logic [31:0] D_in,
   input  logic        DSACK0,
   input  logic        DSACK1,
   input  logic        SENSE
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {StIdle, StAssert, StWaitAck, StHold, StGap, StFinish} state_e;

   state_e         state_q;
   logic [1:0]     kind_q;
   logic [1:0]     sub_q;
   logic           ext_q;
   logic           abort_q;
   logic [79:0]    wdata_q;
   logic [TW-1:0]  tcnt_q;
   logic [GW-1:0]  gcnt_q;
   logic           ack;

   // The last 80-bit subcycle carries 16 bits and is closed by the byte/word ack.
   assign ack   = (sub_q == 2'd2) ? ~DSACK0 : ~DSACK1;
   assign ready = (state_q == StIdle) & SENSE & ~RESET;
   assign SIZE  = 1'b1;

   function automatic logic [31:0] slice(input logic [79:0] w, input logic [1:0] s);
      case (s)
         2'd0:    slice = w[31:0];
         2'd1:    slice = w[63:32];
         default: slice = {16'h0000, w[79:64]};
      endcase
   endfunction

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
         kind_q  <= 2'd0;
         sub_q   <= 2'd0;
         ext_q   <= 1'b0;
         abort_q <= 1'b0;
         wdata_q <= '0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         rdata   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         CS      <= 1'b0;
         AS      <= 1'b0;
         DS      <= 1'b0;
         R_W     <= 1'b1;
         A       <= 5'd0;
         D_out   <= '0;
         D_oe    <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (req && SENSE) begin
                  kind_q  <= kind;
                  A       <= addr;
                  ext_q   <= ext80 && (kind != 2'd0);
                  wdata_q <= wdata;
                  sub_q   <= 2'd0;
                  abort_q <= 1'b0;
                  if (kind == 2'd3) begin
                     state_q <= StFinish;
                     done    <= 1'b1;
                     err     <= 1'b1;
                  end else begin
                     state_q <= StAssert;
                     CS      <= 1'b1;
                     AS      <= 1'b1;
                     DS      <= (kind != 2'd0);
                     R_W     <= (kind != 2'd1);
                     D_oe    <= (kind != 2'd2);
                     D_out   <= wdata[31:0];
                  end
               end
            end
            StAssert: begin
               tcnt_q  <= '0;
               state_q <= StWaitAck;
            end
            StWaitAck: begin
               // An ack on the expiry edge still wins over the timeout.
               if (ack) begin
                  if (kind_q == 2'd2) begin
                     case (sub_q)
                        2'd0:    rdata[31:0]  <= D_in;
                        2'd1:    rdata[63:32] <= D_in;
                        default: rdata[79:64] <= D_in[15:0];
                     endcase
                  end
                  state_q <= StHold;
               end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                  abort_q <= 1'b1;
                  CS      <= 1'b0;
                  AS      <= 1'b0;
                  DS      <= 1'b0;
                  R_W     <= 1'b1;
                  D_oe    <= 1'b0;
                  gcnt_q  <= '0;
                  state_q <= StGap;
               end else begin
                  tcnt_q <= tcnt_q + TW'(1);
               end
            end
            StHold: begin
               CS      <= 1'b0;
               AS      <= 1'b0;
               DS      <= 1'b0;
               R_W     <= 1'b1;
               D_oe    <= 1'b0;
               gcnt_q  <= '0;
               state_q <= StGap;
            end
            StGap: begin
               if (gcnt_q == GW'(GAP - 1)) begin
                  if (abort_q || !ext_q || (sub_q == 2'd2)) begin
                     state_q <= StFinish;
                     done    <= 1'b1;
                     err     <= abort_q;
                  end else begin
                     sub_q   <= sub_q + 2'd1;
                     state_q <= StAssert;
                     CS      <= 1'b1;
                     AS      <= 1'b1;
                     DS      <= 1'b1;
                     R_W     <= (kind_q != 2'd1);
                     D_oe    <= (kind_q == 2'd1);
                     D_out   <= slice(wdata_q, sub_q + 2'd1);
                  end
               end else begin
                  gcnt_q <= gcnt_q + GW'(1);
               end
            end
            StFinish: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mc68881_bus_master.sv
// Bench for mc68881_bus_master: coprocessor responder model, expected-result
// scoreboard checked on each done pulse, plus directed pin checks.
module tb_mc68881_bus_master;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        req = 1'b0;
   logic [1:0]  kind = 2'd0;
   logic [4:0]  addr = 5'd0;
   logic        ext80 = 1'b0;
   logic [79:0] wdata = '0;
   logic [79:0] rdata;
   logic        ready, done, err;
   logic        CS, AS, DS, R_W, SIZE, D_oe;
   logic [4:0]  A;
   logic [31:0] D_out;
   logic [31:0] D_in;
   logic        DSACK0, DSACK1;
   logic        SENSE = 1'b1;

   always #5 CLK = ~CLK;

   mc68881_bus_master #(.TIMEOUT(64), .GAP(2)) dut (
      .CLK(CLK), .RESET(RESET), .req(req), .kind(kind), .addr(addr), .ext80(ext80),
      .wdata(wdata), .rdata(rdata), .ready(ready), .done(done), .err(err),
      .CS(CS), .AS(AS), .DS(DS), .R_W(R_W), .SIZE(SIZE), .A(A), .D_out(D_out),
      .D_oe(D_oe), .D_in(D_in), .DSACK0(DSACK0), .DSACK1(DSACK1), .SENSE(SENSE)
   );

   typedef struct packed {
      logic        e_err;
      logic        chk;
      logic [79:0] rd;
   } exp_t;

   typedef struct packed {
      logic [31:0] dout;
      logic        ds;
      logic        rw;
      logic        doe;
   } obs_t;

   exp_t        sb[$];
   obs_t        obs[$];
   int          gaps[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          resp_mode = 0;  // 0 normal ack, 1 never ack, 2 DSACK0 only
   int          resp_delay = 3;
   int          sub_idx, cs_run, idle_run, cs_rises, last_cs_len, wait_cnt;
   logic        acked;
   logic [79:0] mem [32];

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Coprocessor responder: acks resp_delay negedges after CS rises, stores writes, serves reads.
   initial begin
      DSACK0 = 1'b1; DSACK1 = 1'b1; D_in = '0; acked = 1'b0; wait_cnt = 0;
      sub_idx = 0; cs_run = 0; idle_run = 0; cs_rises = 0; last_cs_len = 0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      forever begin
         @(negedge CLK);
         if (!CS) begin
            if (acked) sub_idx++;
            acked = 1'b0; wait_cnt = 0; DSACK0 = 1'b1; DSACK1 = 1'b1;
            if (cs_run > 0) last_cs_len = cs_run;
            cs_run = 0;
            idle_run++;
         end else begin
            if (cs_run == 0) begin
               cs_rises++;
               if (sub_idx > 0) gaps.push_back(idle_run);
            end
            cs_run++;
            idle_run = 0;
            if (!acked && resp_mode != 1) begin
               if (wait_cnt == resp_delay) begin
                  acked = 1'b1;
                  if (resp_mode == 2 || sub_idx == 2) DSACK0 = 1'b0;
                  else DSACK1 = 1'b0;
                  obs.push_back({D_out, DS, R_W, D_oe});
                  if (!R_W) begin
                     if (sub_idx == 0) mem[A][31:0] = D_out;
                     else if (sub_idx == 1) mem[A][63:32] = D_out;
                     else mem[A][79:64] = D_out[15:0];
                  end else if (DS) begin
                     if (sub_idx == 0) D_in = mem[A][31:0];
                     else if (sub_idx == 1) D_in = mem[A][63:32];
                     else D_in = {16'hBEEF, mem[A][79:64]};
                  end
               end else begin
                  wait_cnt++;
               end
            end
         end
         if (done || RESET) sub_idx = 0;
      end
   end

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (err && !done) check("err_without_done", err, 1'b0);
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_done", done, 1'b0);
            end else begin
               e = sb.pop_front();
               check("sb_err", err, e.e_err);
               if (e.chk) check("sb_rdata", rdata, e.rd);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] k, input logic [4:0] a, input logic e,
                        input logic [79:0] w, input logic exp_err, input logic chk,
                        input logic [79:0] exp_rd, input logic push);
      exp_t x;
      x.e_err = exp_err; x.chk = chk; x.rd = exp_rd;
      if (push) sb.push_back(x);
      @(negedge CLK);
      kind = k; addr = a; ext80 = e; wdata = w; req = 1'b1;
      for (int i = 0; i < 200 && !ready; i++) @(negedge CLK);
      if (!ready) check("accept_timeout", ready, 1'b1);
      @(posedge CLK);
      #1 req = 1'b0;
   endtask

   task automatic wait_done();
      int start;
      start = done_cnt;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         #1;
         if (done_cnt != start) break;
      end
      if (done_cnt == start) check("done_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      int ob, gb, cr, d0;
      // Reset state
      repeat (3) @(negedge CLK);
      #1;
      check("reset_pins", {CS, AS, DS, R_W, SIZE, D_oe, done, err}, 8'b00011000);
      check("reset_bus", {A, D_out}, 37'd0);
      check("reset_rdata", rdata, 80'd0);
      check("ready_in_reset", ready, 1'b0);
      RESET = 1'b0;
      @(negedge CLK); #1;
      check("ready_after_reset", ready, 1'b1);

      // F-line fetch
      ob = obs.size(); resp_delay = 3;
      issue(2'd0, 5'd2, 1'b0, 80'hCAFEBABE, 1'b0, 1'b0, '0, 1'b1);
      wait_done();
      check("fetch_count", obs.size() - ob, 1);
      check("fetch_pins", {obs[ob].dout, obs[ob].ds, obs[ob].rw, obs[ob].doe},
            {32'hCAFEBABE, 3'b011});

      // FPCR write then read
      ob = obs.size();
      issue(2'd1, 5'd8, 1'b0, 80'hA5A5A5A5, 1'b0, 1'b0, '0, 1'b1);
      wait_done();
      check("fpcr_wr_pins", {obs[ob].dout, obs[ob].ds, obs[ob].rw, obs[ob].doe},
            {32'hA5A5A5A5, 3'b101});
      ob = obs.size();
      issue(2'd2, 5'd8, 1'b0, '0, 1'b0, 1'b1, 80'hA5A5A5A5, 1'b1);
      wait_done();
      check("fpcr_rd_pins", {obs[ob].ds, obs[ob].rw, obs[ob].doe}, 3'b110);

      // FP0 80-bit write and read back
      ob = obs.size(); gb = gaps.size(); resp_delay = 2;
      issue(2'd1, 5'd0, 1'b1, 80'h1234_CAFEBABE_DEADBEEF, 1'b0, 1'b0, '0, 1'b1);
      wait_done();
      check("ext_wr_count", obs.size() - ob, 3);
      check("ext_wr_d0", obs[ob].dout, 32'hDEADBEEF);
      check("ext_wr_d1", obs[ob+1].dout, 32'hCAFEBABE);
      check("ext_wr_d2", obs[ob+2].dout, 32'h00001234);
      check("ext_gap_count", gaps.size() - gb, 2);
      check("ext_gap0", gaps[gb], 2);
      check("ext_gap1", gaps[gb+1], 2);
      issue(2'd2, 5'd0, 1'b1, '0, 1'b0, 1'b1, 80'h1234_CAFEBABE_DEADBEEF, 1'b1);
      wait_done();

      // Timeouts: silent responder, then DSACK0 on a 32-bit subcycle
      resp_mode = 1;
      issue(2'd2, 5'd8, 1'b0, '0, 1'b1, 1'b1, 80'h1234_CAFEBABE_DEADBEEF, 1'b1);
      wait_done();
      check("timeout_cs_len", last_cs_len, 65);
      check("timeout_released", {CS, AS, DS, D_oe}, 4'b0000);
      resp_mode = 2;
      issue(2'd1, 5'd4, 1'b0, 80'h1111, 1'b1, 1'b0, '0, 1'b1);
      wait_done();
      resp_mode = 0;

      // Ack on the expiry edge succeeds; one clock later it is too late
      resp_delay = 64;
      issue(2'd1, 5'd5, 1'b0, 80'h2222, 1'b0, 1'b0, '0, 1'b1);
      wait_done();
      resp_delay = 65;
      issue(2'd1, 5'd5, 1'b0, 80'h3333, 1'b1, 1'b0, '0, 1'b1);
      wait_done();
      resp_delay = 2;

      // Reserved kind: error with no bus cycle
      cr = cs_rises;
      issue(2'd3, 5'd1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      wait_done();
      check("reserved_no_bus", cs_rises - cr, 0);

      // ext80 on a fetch stays a single 32-bit subcycle
      ob = obs.size();
      issue(2'd0, 5'd1, 1'b1, 80'hFFFF_00000000_12345678, 1'b0, 1'b0, '0, 1'b1);
      wait_done();
      check("fetch_ext_count", obs.size() - ob, 1);

      // Reset in WAIT_ACK of 80-bit subcycle 1
      resp_delay = 10;
      issue(2'd1, 5'd2, 1'b1, 80'h9999_88887777_66665555, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (sub_idx == 1 && CS) break;
      end
      repeat (3) @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      check("reset_mid_pins", {CS, AS, DS, R_W, D_oe}, 5'b00010);
      d0 = done_cnt;
      repeat (4) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK); #1;
      check("reset_mid_ready", ready, 1'b1);
      check("reset_mid_no_done", done_cnt - d0, 0);
      resp_delay = 2;
      issue(2'd1, 5'd8, 1'b0, 80'h55AA55AA, 1'b0, 1'b0, '0, 1'b1);
      wait_done();
      issue(2'd2, 5'd8, 1'b0, '0, 1'b0, 1'b1, 80'h55AA55AA, 1'b1);
      wait_done();

      // SENSE gating; SENSE falling mid-transaction must not abort it
      ob = obs.size();
      sb.push_back({1'b0, 1'b0, 80'd0});
      @(negedge CLK);
      SENSE = 1'b0; kind = 2'd1; addr = 5'd9; ext80 = 1'b0; wdata = 80'h11223344; req = 1'b1;
      cr = cs_rises;
      repeat (5) @(negedge CLK);
      check("gated_ready", ready, 1'b0);
      check("gated_no_bus", cs_rises - cr, 0);
      SENSE = 1'b1;
      @(posedge CLK);
      #1 req = 1'b0;
      check("sense_accept", CS, 1'b1);
      SENSE = 1'b0;
      wait_done();
      check("sense_wr_data", obs[ob].dout, 32'h11223344);
      SENSE = 1'b1;

      repeat (3) @(negedge CLK);
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mc68881_bus_master.md
MC68881_BUS_MASTER -- requirements
Module: mc68881_bus_master

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: RESET  in  1  asynchronous, active-high.
REQ-003 SHALL have host side: req in 1 (start); kind in 2 (0=F-line fetch, 1=write, 2=read, 3=reserved->err); addr in 5 (register select); ext80 in 1 (80-bit FPn transfer); wdata in 80; rdata out 80; ready out 1; done out 1 (1-cycle pulse); err out 1 (1-cycle pulse, with done).
REQ-004 SHALL have pin side: CS, AS, DS, R_W, SIZE out 1 each; A out 5; D_out out 32; D_oe out 1; D_in in 32; DSACK0, DSACK1 in 1 (active-low); SENSE in 1 (coprocessor ready).
REQ-005 Parameters: TIMEOUT, default 64, clocks in WAIT_ACK before abort; GAP, default 2, idle clocks between subcycles.

Function
REQ-006 States: IDLE, ASSERT, WAIT_ACK, HOLD, GAP, FINISH.
REQ-007 ready SHALL be 1 only in IDLE with SENSE=1; req sampled only when ready=1, else ignored.
REQ-008 On accept: latch kind, addr, ext80, wdata; subcycle index=0; next state ASSERT.
REQ-009 ASSERT (1 clock) then WAIT_ACK: CS=AS=1, A=latched addr, SIZE=1; fetch: DS=0, R_W=1, D_oe=1, D_out=wdata[31:0]; write: DS=1, R_W=0, D_oe=1; read: DS=1, R_W=1, D_oe=0.
REQ-010 Subcycles: non-ext80 = 1 subcycle of 32 bits; ext80 (write/read only) = 3 subcycles, same addr: 0 = bits[31:0], 1 = bits[63:32], 2 = bits[79:64] on D[15:0], D_out[31:16]=0.
REQ-011 Expected ack: subcycles 0/1 and non-ext80 -> DSACK1=0; subcycle 2 -> DSACK0=0; other combinations ignored (keep waiting).
REQ-012 In WAIT_ACK, on expected ack sampled at a rising edge: read captures D_in (subcycle 2: D_in[15:0] only) into rdata slice same edge; go HOLD.
REQ-013 HOLD: all pin signals unchanged for 1 clock, then GAP.
REQ-014 GAP: CS=AS=DS=0, R_W=1, D_oe=0 for GAP clocks; then ASSERT of next subcycle if remaining, else FINISH.
REQ-015 FINISH: done=1 for 1 clock, err=0; return to IDLE.
REQ-016 Timeout counter counts clocks in WAIT_ACK, cleared on ASSERT; at TIMEOUT with no expected ack: deassert bus (GAP), then FINISH with done=1, err=1; remaining subcycles abandoned; rdata slices not yet captured unchanged.
REQ-017 kind=3 on accept: no bus cycle; FINISH next clock with err=1.
REQ-018 ext80 with kind=0 SHALL be treated as single 32-bit fetch.
REQ-019 rdata SHALL hold last captured value until overwritten by a later read; not cleared at start of read.
REQ-020 SENSE falling during a transaction SHALL not abort it; only gates new accepts.
REQ-021 Ack arriving on the same edge as timeout expiry SHALL be treated as success.

Reset
REQ-022 RESET=1 SHALL immediately (asynchronously) force IDLE, CS=AS=DS=0, R_W=1, SIZE=1, A=0, D_oe=0, D_out=0, done=err=0, rdata=0, counters 0.
REQ-023 Reset mid-transaction SHALL abandon it with no done pulse; ready re-asserts on first clock after release if SENSE=1.

Verification
REQ-024 Fetch: kind=0, wdata[31:0]=CAFEBABE, responder DSACK1=0 after 3 clocks -> D_out=CAFEBABE, DS=0, R_W=1 during cycle; done 1 clock, err=0.
REQ-025 FPCR: write addr=01000 data A5A5A5A5 then read addr=01000 -> R_W=0 during write; rdata[31:0]=A5A5A5A5, done each, err=0.
REQ-026 FP0 80-bit: write ext80 addr=00000 wdata=1234_CAFEBABE_DEADBEEF -> three subcycles D_out DEADBEEF, CAFEBABE, 00001234, third acked by DSACK0, GAP>=2 idle clocks between; read back -> rdata=1234_CAFEBABE_DEADBEEF.
REQ-027 Timeout: read, no DSACK asserted -> after 64 WAIT_ACK clocks bus released, done=err=1; DSACK0-only on a 32-bit subcycle also times out.
REQ-028 Reset mid-op: RESET asserted during WAIT_ACK of ext80 subcycle 1 -> pins deasserted same time step, no done; new request after release completes normally.
REQ-029 Gating: SENSE=0 with req=1 -> ready=0, no bus activity; SENSE rises -> request accepted next edge.
